mem_port_arbiter: RTL and testbench

Synthesizable, clocked responder for the CPU's four-phase RAM request handshake. It serves three initiators: fetch read, load read and store write. Each transaction is arbitrated and driven onto a single synchronous RAM port with 1-cycle read latency. The block replaces the event-driven RAM prioritizer between the pipeline stages and the RAM model.

---
 rtl/mem_port_arbiter.sv | 176 +++++++++++++++++
 tb/tb_mem_port_arbiter.sv | 212 +++++++++++++++++++++
 2 files changed

// File: rtl/mem_port_arbiter.sv
// Arbitrates fetch/load/store four-phase requests onto one synchronous RAM port
// with 1-cycle read latency; store > load > fetch, with optional fetch aging.
module mem_port_arbiter #(
  parameter int ADDR_W       = 16,
  parameter int DATA_W       = 8,
  parameter int STARVE_LIMIT = 4
) (
  input  logic              ram_clk,
  input  logic              rst,
  input  logic              fetch_read,
  output logic              fetch_read_ready,
  input  logic [ADDR_W-1:0] fetch_read_address,
  output logic [DATA_W-1:0] fetch_read_data_out,
  input  logic              load_read,
  output logic              load_read_ready,
  input  logic [ADDR_W-1:0] load_read_address,
  output logic [DATA_W-1:0] load_read_data_out,
  input  logic              store_save,
  output logic              store_save_ready,
  input  logic [ADDR_W-1:0] store_save_address,
  input  logic [DATA_W-1:0] store_save_data_in,
  output logic              mem_write_enable,
  output logic [ADDR_W-1:0] mem_address,
  output logic [DATA_W-1:0] mem_data_in,
  input  logic [DATA_W-1:0] mem_data_out,
  output logic              busy
);

  typedef enum logic [1:0] {IDLE, ISSUE, CAPTURE, DONE} state_e;
  typedef enum logic [1:0] {GNT_FETCH, GNT_LOAD, GNT_STORE} gnt_e;

  localparam int CNT_W = (STARVE_LIMIT < 1) ? 1 : $clog2(STARVE_LIMIT + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STARVE_LIMIT);

  state_e            state_q, state_d;
  gnt_e              gnt_q, gnt_d;
  logic [CNT_W-1:0]  starve_q, starve_d;
  logic              mem_we_q, mem_we_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
  logic [DATA_W-1:0] fetch_data_q, fetch_data_d;
  logic [DATA_W-1:0] load_data_q, load_data_d;
  logic              fetch_rdy_q, fetch_rdy_d;
  logic              load_rdy_q, load_rdy_d;
  logic              store_rdy_q, store_rdy_d;
  logic              gnt_req;
  logic              fetch_aged;

  always_comb begin
    state_d      = state_q;
    gnt_d        = gnt_q;
    starve_d     = starve_q;
    mem_we_d     = mem_we_q;
    mem_addr_d   = mem_addr_q;
    mem_wdata_d  = mem_wdata_q;
    fetch_data_d = fetch_data_q;
    load_data_d  = load_data_q;
    fetch_rdy_d  = fetch_rdy_q;
    load_rdy_d   = load_rdy_q;
    store_rdy_d  = store_rdy_q;

    case (gnt_q)
      GNT_STORE: gnt_req = store_save;
      GNT_LOAD:  gnt_req = load_read;
      default:   gnt_req = fetch_read;
    endcase
    fetch_aged = (STARVE_LIMIT != 0) && (starve_q >= CNT_MAX);

    case (state_q)
      IDLE: begin
        if (!fetch_read) starve_d = '0;
        if (fetch_read || load_read || store_save) begin
          state_d = ISSUE;
          if (fetch_read && fetch_aged)  gnt_d = GNT_FETCH;
          else if (store_save)           gnt_d = GNT_STORE;
          else if (load_read)            gnt_d = GNT_LOAD;
          else                           gnt_d = GNT_FETCH;

          case (gnt_d)
            GNT_STORE: begin
              mem_addr_d  = store_save_address;
              mem_wdata_d = store_save_data_in;
              mem_we_d    = 1'b1;
            end
            GNT_LOAD: begin
              mem_addr_d = load_read_address;
              mem_we_d   = 1'b0;
            end
            default: begin
              mem_addr_d = fetch_read_address;
              mem_we_d   = 1'b0;
            end
          endcase

          // Aging: fetch loses a grant only when it was actually waiting.
          if (gnt_d == GNT_FETCH)
            starve_d = '0;
          else if (fetch_read && (starve_q < CNT_MAX))
            starve_d = starve_q + CNT_W'(1);
        end
      end
      ISSUE: begin
        mem_we_d = 1'b0;
        if (gnt_q == GNT_STORE) begin
          // Write already happened at this edge; a dropped request skips DONE.
          if (store_save) begin
            store_rdy_d = 1'b1;
            state_d     = DONE;
          end else begin
            state_d = IDLE;
          end
        end else begin
          state_d = CAPTURE;
        end
      end
      CAPTURE: begin
        if (gnt_q == GNT_LOAD) begin
          load_data_d = mem_data_out;
          load_rdy_d  = load_read;
        end else begin
          fetch_data_d = mem_data_out;
          fetch_rdy_d  = fetch_read;
        end
        state_d = gnt_req ? DONE : IDLE;
      end
      DONE: begin
        if (!gnt_req) begin
          fetch_rdy_d = 1'b0;
          load_rdy_d  = 1'b0;
          store_rdy_d = 1'b0;
          state_d     = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge ram_clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      gnt_q        <= GNT_FETCH;
      starve_q     <= '0;
      mem_we_q     <= 1'b0;
      mem_addr_q   <= '0;
      mem_wdata_q  <= '0;
      fetch_data_q <= '0;
      load_data_q  <= '0;
      fetch_rdy_q  <= 1'b0;
      load_rdy_q   <= 1'b0;
      store_rdy_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      gnt_q        <= gnt_d;
      starve_q     <= starve_d;
      mem_we_q     <= mem_we_d;
      mem_addr_q   <= mem_addr_d;
      mem_wdata_q  <= mem_wdata_d;
      fetch_data_q <= fetch_data_d;
      load_data_q  <= load_data_d;
      fetch_rdy_q  <= fetch_rdy_d;
      load_rdy_q   <= load_rdy_d;
      store_rdy_q  <= store_rdy_d;
    end
  end

  assign fetch_read_ready    = fetch_rdy_q;
  assign load_read_ready     = load_rdy_q;
  assign store_save_ready    = store_rdy_q;
  assign fetch_read_data_out = fetch_data_q;
  assign load_read_data_out  = load_data_q;
  assign mem_write_enable    = mem_we_q;
  assign mem_address         = mem_addr_q;
  assign mem_data_in         = mem_wdata_q;
  assign busy                = (state_q != IDLE);

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter with a behavioural 1-cycle-latency RAM.
module tb_mem_port_arbiter;

  logic        ram_clk = 1'b0;
  logic        rst = 1'b1;
  logic        fetch_read = 1'b0, load_read = 1'b0, store_save = 1'b0;
  logic [15:0] fetch_read_address = '0, load_read_address = '0, store_save_address = '0;
  logic [7:0]  store_save_data_in = '0;
  logic        fetch_read_ready, load_read_ready, store_save_ready;
  logic [7:0]  fetch_read_data_out, load_read_data_out;
  logic        mem_write_enable, busy;
  logic [15:0] mem_address;
  logic [7:0]  mem_data_in, mem_data_out;

  int checks = 0;
  int failures = 0;

  always #5 ram_clk = ~ram_clk;

  mem_port_arbiter #(.ADDR_W(16), .DATA_W(8), .STARVE_LIMIT(2)) dut (
    .ram_clk(ram_clk), .rst(rst),
    .fetch_read(fetch_read), .fetch_read_ready(fetch_read_ready),
    .fetch_read_address(fetch_read_address), .fetch_read_data_out(fetch_read_data_out),
    .load_read(load_read), .load_read_ready(load_read_ready),
    .load_read_address(load_read_address), .load_read_data_out(load_read_data_out),
    .store_save(store_save), .store_save_ready(store_save_ready),
    .store_save_address(store_save_address), .store_save_data_in(store_save_data_in),
    .mem_write_enable(mem_write_enable), .mem_address(mem_address),
    .mem_data_in(mem_data_in), .mem_data_out(mem_data_out), .busy(busy)
  );

  // Synchronous RAM: samples address/we at posedge, read data one edge later.
  logic [7:0] ram [0:255];
  always @(posedge ram_clk) begin
    if (rst) begin
      ram[0]       <= 8'h10;
      mem_data_out <= '0;
    end else begin
      if (mem_write_enable) ram[mem_address[7:0]] <= mem_data_in;
      mem_data_out <= ram[mem_address[7:0]];
    end
  end

  task automatic tick();
    @(posedge ram_clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick(); tick();
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b exp=0", busy); end
    checks++; if (mem_write_enable !== 1'b0) begin failures++; $display("FAIL reset_we got=%b exp=0", mem_write_enable); end
    checks++; if ({fetch_read_ready, load_read_ready, store_save_ready} !== 3'b000) begin failures++; $display("FAIL reset_ready got=%b exp=000", {fetch_read_ready, load_read_ready, store_save_ready}); end
    checks++; if (mem_address !== 16'h0000) begin failures++; $display("FAIL reset_addr got=%h exp=0000", mem_address); end
    checks++; if ({fetch_read_data_out, load_read_data_out} !== 16'h0000) begin failures++; $display("FAIL reset_data got=%h exp=0000", {fetch_read_data_out, load_read_data_out}); end
    rst = 1'b0;
    tick();
  endtask

  task automatic test_fetch_read();
    fetch_read_address = 16'h0000;
    fetch_read = 1'b1;
    tick();
    checks++; if (busy !== 1'b1) begin failures++; $display("FAIL fetch_busy got=%b exp=1", busy); end
    checks++; if (mem_write_enable !== 1'b0) begin failures++; $display("FAIL fetch_we got=%b exp=0", mem_write_enable); end
    checks++; if (fetch_read_ready !== 1'b0) begin failures++; $display("FAIL fetch_ready_e0 got=%b exp=0", fetch_read_ready); end
    tick();
    checks++; if (fetch_read_ready !== 1'b0) begin failures++; $display("FAIL fetch_ready_e1 got=%b exp=0", fetch_read_ready); end
    tick();
    checks++; if (fetch_read_ready !== 1'b1) begin failures++; $display("FAIL fetch_ready_e2 got=%b exp=1", fetch_read_ready); end
    checks++; if (fetch_read_data_out !== 8'h10) begin failures++; $display("FAIL fetch_data got=%h exp=10", fetch_read_data_out); end
    tick();
    checks++; if (fetch_read_ready !== 1'b1) begin failures++; $display("FAIL fetch_ready_hold got=%b exp=1", fetch_read_ready); end
    fetch_read = 1'b0;
    tick();
    checks++; if (fetch_read_ready !== 1'b0) begin failures++; $display("FAIL fetch_ready_fall got=%b exp=0", fetch_read_ready); end
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL fetch_idle got=%b exp=0", busy); end
    tick();
  endtask

  task automatic test_store_then_load();
    store_save_address = 16'h0020;
    store_save_data_in = 8'hA5;
    store_save = 1'b1;
    tick();
    checks++; if (mem_write_enable !== 1'b1) begin failures++; $display("FAIL store_we_e0 got=%b exp=1", mem_write_enable); end
    checks++; if ({mem_address, mem_data_in} !== 24'h0020A5) begin failures++; $display("FAIL store_port got=%h exp=0020a5", {mem_address, mem_data_in}); end
    checks++; if (store_save_ready !== 1'b0) begin failures++; $display("FAIL store_ready_e0 got=%b exp=0", store_save_ready); end
    store_save_address = 16'h0030;
    store_save_data_in = 8'hFF;
    tick();
    checks++; if (mem_write_enable !== 1'b0) begin failures++; $display("FAIL store_we_e1 got=%b exp=0", mem_write_enable); end
    checks++; if (store_save_ready !== 1'b1) begin failures++; $display("FAIL store_ready_e1 got=%b exp=1", store_save_ready); end
    checks++; if (mem_address !== 16'h0020) begin failures++; $display("FAIL store_addr_hold got=%h exp=0020", mem_address); end
    store_save = 1'b0;
    tick();
    checks++; if (store_save_ready !== 1'b0) begin failures++; $display("FAIL store_ready_fall got=%b exp=0", store_save_ready); end
    load_read_address = 16'h0020;
    load_read = 1'b1;
    tick(); tick();
    checks++; if (load_read_ready !== 1'b0) begin failures++; $display("FAIL load_ready_e1 got=%b exp=0", load_read_ready); end
    tick();
    checks++; if (load_read_ready !== 1'b1) begin failures++; $display("FAIL load_ready_e2 got=%b exp=1", load_read_ready); end
    checks++; if (load_read_data_out !== 8'hA5) begin failures++; $display("FAIL load_data got=%h exp=a5", load_read_data_out); end
    load_read = 1'b0;
    tick(); tick();
  endtask

  task automatic test_simultaneous();
    string seq = "";
    fetch_read_address = 16'h0000;
    load_read_address  = 16'h0020;
    store_save_address = 16'h0040;
    store_save_data_in = 8'h5C;
    fetch_read = 1'b1; load_read = 1'b1; store_save = 1'b1;
    for (int i = 0; i < 40 && seq.len() < 3; i++) begin
      tick();
      checks++;
      if ((fetch_read_ready && !fetch_read) || (load_read_ready && !load_read) ||
          (store_save_ready && !store_save) ||
          (int'(fetch_read_ready) + int'(load_read_ready) + int'(store_save_ready) > 1)) begin
        failures++;
        $display("FAIL simul_ready_own got=%b exp=one ready with own request", {fetch_read_ready, load_read_ready, store_save_ready});
      end
      if (store_save_ready) begin seq = {seq, "S"}; store_save = 1'b0; end
      if (load_read_ready)  begin seq = {seq, "L"}; load_read = 1'b0; end
      if (fetch_read_ready) begin seq = {seq, "F"}; fetch_read = 1'b0; end
    end
    checks++; if (seq != "SLF") begin failures++; $display("FAIL simul_order got=%s exp=SLF", seq); end
    checks++; if ({load_read_data_out, fetch_read_data_out} !== 16'hA510) begin failures++; $display("FAIL simul_data got=%h exp=a510", {load_read_data_out, fetch_read_data_out}); end
    fetch_read = 1'b0; load_read = 1'b0; store_save = 1'b0;
    tick(); tick();
  endtask

  task automatic test_starvation();
    string seq = "";
    int nstore = 0;
    logic reraise = 1'b0;
    fetch_read_address = 16'h0000;
    store_save_address = 16'h0060;
    store_save_data_in = 8'h11;
    fetch_read = 1'b1; store_save = 1'b1;
    for (int i = 0; i < 80 && seq.len() < 4; i++) begin
      tick();
      if (reraise) begin store_save = 1'b1; reraise = 1'b0; end
      if (store_save_ready && store_save) begin
        seq = {seq, "S"}; nstore++; store_save = 1'b0; reraise = (nstore < 3);
      end
      if (fetch_read_ready && fetch_read) begin seq = {seq, "F"}; fetch_read = 1'b0; end
    end
    checks++; if (seq != "SSFS") begin failures++; $display("FAIL starve_order got=%s exp=SSFS", seq); end
    fetch_read = 1'b0; store_save = 1'b0;
    tick(); tick();
  endtask

  task automatic test_early_drop();
    logic saw_ready = 1'b0;
    load_read_address = 16'h0020;
    load_read = 1'b1;
    tick();
    checks++; if (busy !== 1'b1) begin failures++; $display("FAIL drop_busy_grant got=%b exp=1", busy); end
    load_read = 1'b0;
    tick();
    saw_ready = saw_ready | load_read_ready;
    tick();
    saw_ready = saw_ready | load_read_ready;
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL drop_busy_end got=%b exp=0", busy); end
    tick();
    saw_ready = saw_ready | load_read_ready;
    checks++; if (saw_ready !== 1'b0) begin failures++; $display("FAIL drop_ready got=%b exp=0", saw_ready); end
  endtask

  task automatic test_reset_mid();
    store_save_address = 16'h0080;
    store_save_data_in = 8'h77;
    store_save = 1'b1;
    tick();
    checks++; if (mem_write_enable !== 1'b1) begin failures++; $display("FAIL rstmid_we_before got=%b exp=1", mem_write_enable); end
    #2 rst = 1'b1;
    #1;
    checks++; if (mem_write_enable !== 1'b0) begin failures++; $display("FAIL rstmid_we got=%b exp=0", mem_write_enable); end
    checks++; if ({fetch_read_ready, load_read_ready, store_save_ready, busy} !== 4'b0000) begin failures++; $display("FAIL rstmid_outs got=%b exp=0000", {fetch_read_ready, load_read_ready, store_save_ready, busy}); end
    tick();
    rst = 1'b0;
    store_save = 1'b0;
    tick(); tick();
    checks++; if ({store_save_ready, busy} !== 2'b00) begin failures++; $display("FAIL rstmid_after got=%b exp=00", {store_save_ready, busy}); end
    fetch_read_address = 16'h0000;
    fetch_read = 1'b1;
    tick(); tick();
    checks++; if (fetch_read_ready !== 1'b0) begin failures++; $display("FAIL rstmid_fetch_early got=%b exp=0", fetch_read_ready); end
    tick();
    checks++; if ({fetch_read_ready, fetch_read_data_out} !== 9'h110) begin failures++; $display("FAIL rstmid_fetch got=%h exp=110", {fetch_read_ready, fetch_read_data_out}); end
    fetch_read = 1'b0;
    tick();
    checks++; if (fetch_read_ready !== 1'b0) begin failures++; $display("FAIL rstmid_fetch_fall got=%b exp=0", fetch_read_ready); end
  endtask

  initial begin
    test_reset();
    test_fetch_read();
    test_store_then_load();
    test_simultaneous();
    test_starvation();
    test_early_drop();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
